gpu_command_executor: RTL

GPU_COMMAND_EXECUTOR -- requirements
Module: gpu_command_executor

---
 rtl/gpu_command_executor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/gpu_command_executor.sv
// Command executor for a small 8-bit framebuffer: latches one instruction,
// decodes it, streams pixel writes to VRAM with stall support, then handshakes done.
module gpu_command_executor #(
  parameter int unsigned H_RES  = 160,
  parameter int unsigned V_RES  = 120,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [31:0]       i_instruction,
  input  logic              i_ready,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_error,
  output logic              o_vram_we,
  output logic [ADDR_W-1:0] o_vram_addr,
  output logic [7:0]        o_vram_data,
  input  logic              i_vram_stall
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_SET_COLOR = 8'h01;
  localparam logic [7:0] OP_PLOT      = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h03;
  localparam logic [7:0] OP_HLINE     = 8'h04;

  // One extra bit so a full-frame pixel count is representable.
  localparam int unsigned      CNT_W        = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME_PIXELS = CNT_W'(H_RES * V_RES);

  logic [2:0]        state_q,  state_d;
  logic [31:0]       instr_q,  instr_d;
  logic [7:0]        colour_q, colour_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [7:0]        data_q,   data_d;
  logic              we_q,     we_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              err_q,    err_d;

  logic [7:0]        op, arg0, arg1, arg2;
  logic              xy_in_range;
  logic [ADDR_W-1:0] pix_addr;
  logic [31:0]       hline_room, hline_len;

  assign op   = instr_q[7:0];
  assign arg0 = instr_q[15:8];
  assign arg1 = instr_q[23:16];
  assign arg2 = instr_q[31:24];

  assign xy_in_range = (32'(arg0) < H_RES) && (32'(arg1) < V_RES);
  assign pix_addr    = ADDR_W'(arg1) * ADDR_W'(H_RES) + ADDR_W'(arg0);
  // Only meaningful when x is on screen; clipping keeps the line on its own row.
  assign hline_room  = H_RES - 32'(arg0);
  assign hline_len   = (32'(arg2) < hline_room) ? 32'(arg2) : hline_room;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block infers a latch.
    state_d  = state_q;
    instr_d  = instr_q;
    colour_d = colour_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (i_ready) begin
          instr_d = i_instruction;
          err_d   = 1'b0;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_DONE;
        case (op)
          OP_NOP: ;
          OP_SET_COLOR: colour_d = arg0;
          OP_PLOT: begin
            if (xy_in_range) begin
              addr_d  = pix_addr;
              data_d  = colour_q;
              cnt_d   = CNT_W'(1);
              we_d    = 1'b1;
              state_d = S_WRITE;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_CLEAR: begin
            addr_d  = '0;
            data_d  = arg0;
            cnt_d   = FRAME_PIXELS;
            we_d    = 1'b1;
            state_d = S_WRITE;
          end
          OP_HLINE: begin
            if (xy_in_range && (arg2 != 8'd0)) begin
              addr_d  = pix_addr;
              data_d  = colour_q;
              cnt_d   = CNT_W'(hline_len);
              we_d    = 1'b1;
              state_d = S_WRITE;
            end
          end
          default: err_d = 1'b1;
        endcase
      end

      S_WRITE: begin
        if (we_q) begin
          if (!i_vram_stall) begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) we_d = 1'b0;
          end
        end else begin
          // Settle cycle after the final accepted pixel, then report completion.
          state_d = S_DONE;
        end
      end

      S_DONE:    state_d = S_RELEASE;

      S_RELEASE: if (!i_ready) state_d = S_IDLE;

      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      colour_q <= 8'hFF;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      colour_q <= colour_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign o_done      = (state_q == S_DONE);
  assign o_error     = o_done && err_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_vram_we   = we_q;
  assign o_vram_addr = addr_q;
  assign o_vram_data = data_q;

endmodule
